// File: rtl/elastic_fifo_buffer_pkg.sv
// rtl/elastic_fifo_buffer_pkg.sv - shared types and pointer helper for the elastic FIFO buffer
package elastic_fifo_buffer_pkg;

    // Source that the output register loads from on a given cycle.
    typedef enum logic [1:0] {
        OUT_HOLD      = 2'd0,
        OUT_FROM_RING = 2'd1,
        OUT_BYPASS    = 2'd2,
        OUT_EMPTY     = 2'd3
    } out_sel_e;

    // Ring pointers wrap by compare so that non-power-of-2 depths work.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned last);
        return (ptr == last) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/elastic_ring_store.sv
// rtl/elastic_ring_store.sv - register-array ring with wrapping pointers, push/pop/clear
module elastic_ring_store
    import elastic_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RING_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_empty
);

    localparam int PTR_W  = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
    localparam int USED_W = $clog2(RING_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [RING_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [USED_W-1:0]     r_used;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= PTR_W'(ptr_wrap_inc(32'(r_wr_ptr), 32'(RING_DEPTH - 1)));
            if (i_pop)
                r_rd_ptr <= PTR_W'(ptr_wrap_inc(32'(r_rd_ptr), 32'(RING_DEPTH - 1)));
            r_used <= r_used + USED_W'(i_push) - USED_W'(i_pop);
        end
    end

    // Storage carries no reset; stale contents are never observable past the pointers.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_empty     = (r_used == '0);

endmodule

// File: rtl/elastic_fifo_buffer.sv
// rtl/elastic_fifo_buffer.sv - DEPTH-entry elastic buffer with registered output, s_ready and flags
module elastic_fifo_buffer
    import elastic_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full
);

    logic [CNT_W-1:0]      r_count;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_s_ready;
    logic                  r_almost_full;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_ring_empty;
    logic [DATA_WIDTH-1:0] w_ring_head;
    logic                  w_ring_push;
    logic                  w_ring_pop;
    logic [CNT_W-1:0]      w_count_next;
    out_sel_e              w_out_sel;

    assign w_accept     = s_valid && r_s_ready;
    assign w_pop        = r_m_valid && m_ready;
    assign w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

    // Bypass only while the ring is empty, otherwise FIFO order would break.
    always_comb begin
        w_out_sel = OUT_HOLD;
        if (w_pop) begin
            if (!w_ring_empty)
                w_out_sel = OUT_FROM_RING;
            else if (w_accept)
                w_out_sel = OUT_BYPASS;
            else
                w_out_sel = OUT_EMPTY;
        end else if (!r_m_valid && w_accept) begin
            w_out_sel = OUT_BYPASS;
        end
    end

    assign w_ring_pop  = (w_out_sel == OUT_FROM_RING);
    assign w_ring_push = w_accept && (w_out_sel != OUT_BYPASS);

    elastic_ring_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .RING_DEPTH (DEPTH - 1)
    ) u_ring (
        .clk         (clk),
        .rstn        (rstn),
        .i_clear     (flush),
        .i_push      (w_ring_push),
        .i_push_data (s_data),
        .i_pop       (w_ring_pop),
        .o_head_data (w_ring_head),
        .o_empty     (w_ring_empty)
    );

    // Flags come from the next count so they are plain flops at the ports.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count       <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_s_ready     <= 1'b1;
            r_almost_full <= 1'b0;
        end else if (flush) begin
            r_count       <= '0;
            r_m_valid     <= 1'b0;
            r_s_ready     <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_s_ready     <= (w_count_next != CNT_W'(DEPTH));
            r_almost_full <= (w_count_next >= CNT_W'(AF_THRESH));
            case (w_out_sel)
                OUT_FROM_RING: begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= w_ring_head;
                end
                OUT_BYPASS: begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= s_data;
                end
                OUT_EMPTY: r_m_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign count       = r_count;
    assign almost_full = r_almost_full;

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// tb/tb_elastic_fifo_buffer.sv - self-checking bench for elastic_fifo_buffer
module tb_elastic_fifo_buffer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, AF_THRESH=3, 8-bit data
    logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_af;
    logic [7:0] a_s_data, a_m_data;
    logic [2:0] a_count;

    // Instance B: DEPTH=5, default AF_THRESH=4, 16-bit data
    logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_af;
    logic [15:0] b_s_data, b_m_data;
    logic [2:0]  b_count;

    elastic_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3)) u_dut_a (
        .clk(clk), .rstn(rstn), .flush(a_flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count), .almost_full(a_af)
    );

    elastic_fifo_buffer #(.DATA_WIDTH(16), .DEPTH(5)) u_dut_b (
        .clk(clk), .rstn(rstn), .flush(b_flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count), .almost_full(b_af)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  qa[$];
    logic [15:0] qb[$];
    int          b_popped = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the buffer is an ordered queue of at most DEPTH beats.
    task automatic model_step();
        bit acc, pop;
        acc = a_s_valid && (qa.size() != 4);
        pop = a_m_ready && (qa.size() != 0);
        if (a_flush) qa.delete();
        else begin
            if (pop) void'(qa.pop_front());
            if (acc) qa.push_back(a_s_data);
        end
        acc = b_s_valid && (qb.size() != 5);
        pop = b_m_ready && (qb.size() != 0);
        if (b_flush) qb.delete();
        else begin
            if (pop) begin void'(qb.pop_front()); b_popped++; end
            if (acc) qb.push_back(b_s_data);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_a_count"}, 32'(a_count), 32'(qa.size()));
        chk({tag, "_a_mvalid"}, 32'(a_m_valid), 32'(qa.size() != 0));
        chk({tag, "_a_sready"}, 32'(a_s_ready), 32'(qa.size() != 4));
        chk({tag, "_a_af"}, 32'(a_af), 32'(qa.size() >= 3));
        if (qa.size() != 0) chk({tag, "_a_mdata"}, 32'(a_m_data), 32'(qa[0]));
    endtask

    task automatic check_b(input string tag);
        chk({tag, "_b_count"}, 32'(b_count), 32'(qb.size()));
        chk({tag, "_b_mvalid"}, 32'(b_m_valid), 32'(qb.size() != 0));
        chk({tag, "_b_sready"}, 32'(b_s_ready), 32'(qb.size() != 5));
        chk({tag, "_b_af"}, 32'(b_af), 32'(qb.size() >= 4));
        if (qb.size() != 0) chk({tag, "_b_mdata"}, 32'(b_m_data), 32'(qb[0]));
    endtask

    initial begin
        logic [7:0]  got[$];
        logic [7:0]  exp_order[5];
        int          bubbles;
        bit          drop_valid;
        bit          prev_stall;
        logic [15:0] prev_data;

        rstn = 1'b0;
        a_flush = 0; a_s_valid = 0; a_m_ready = 0; a_s_data = '0;
        b_flush = 0; b_s_valid = 0; b_m_ready = 0; b_s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_mdata", 32'(a_m_data), 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_a("reset");
        check_b("reset");

        // Single beat, one-cycle latency
        a_s_valid = 1; a_s_data = 8'hA5; a_m_ready = 1;
        cycle();
        a_s_valid = 0;
        chk("single_mvalid", 32'(a_m_valid), 32'h1);
        chk("single_mdata", 32'(a_m_data), 32'hA5);
        chk("single_count", 32'(a_count), 32'h1);
        cycle();
        chk("single_drain_count", 32'(a_count), 32'h0);
        chk("single_drain_mvalid", 32'(a_m_valid), 32'h0);

        // Streaming 16 beats back to back
        for (int i = 0; i < 16; i++) begin
            a_s_valid = 1; a_s_data = 8'(i);
            chk("stream_sready_pre", 32'(a_s_ready), 32'h1);
            cycle();
            chk("stream_mdata", 32'(a_m_data), 32'(i));
            check_a("stream");
        end
        a_s_valid = 0;
        cycle();
        check_a("stream_end");

        // Backpressure: fill to full, then drain with the fifth beat pending
        a_m_ready = 0;
        for (int v = 1; v <= 5; v++) begin
            a_s_valid = 1; a_s_data = 8'(v);
            cycle();
            check_a("bp_fill");
        end
        chk("bp_full_sready", 32'(a_s_ready), 32'h0);
        chk("bp_full_af", 32'(a_af), 32'h1);
        a_m_ready = 1;
        bubbles = 0;
        for (int k = 0; k < 20 && got.size() < 5; k++) begin
            if (a_m_valid) got.push_back(a_m_data);
            drop_valid = a_s_valid && a_s_ready;
            if (a_s_valid && !a_s_ready) bubbles++;
            cycle();
            if (drop_valid) a_s_valid = 0;
            check_a("bp_drain");
        end
        chk("bp_drain_len", 32'(got.size()), 32'd5);
        exp_order = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk("bp_order", 32'(got[k]), 32'(exp_order[k]));
        chk("bp_bubbles", 32'(bubbles), 32'd1);
        a_s_valid = 0;
        cycle();

        // Flush at count=3 with a beat offered in the same cycle
        a_m_ready = 0;
        for (int v = 0; v < 3; v++) begin
            a_s_valid = 1; a_s_data = 8'h11 * 8'(v + 1);
            cycle();
        end
        chk("flush_pre_count", 32'(a_count), 32'd3);
        a_s_valid = 1; a_s_data = 8'h44; a_flush = 1;
        cycle();
        a_flush = 0; a_s_valid = 0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_mvalid", 32'(a_m_valid), 32'h0);
        chk("flush_sready", 32'(a_s_ready), 32'h1);
        a_m_ready = 1;
        repeat (4) begin
            cycle();
            chk("flush_no_output", 32'(a_m_valid), 32'h0);
        end

        // Random traffic on the DEPTH=5 instance
        prev_stall = 0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 20000 && b_popped < 2000; cyc++) begin
            b_s_valid = ($urandom_range(0, 99) < 60);
            b_s_data  = 16'($urandom);
            b_m_ready = ($urandom_range(0, 99) < 55);
            b_flush   = ($urandom_range(0, 499) == 0);
            prev_stall = b_m_valid && !b_m_ready && !b_flush;
            prev_data  = b_m_data;
            cycle();
            check_b("rand");
            if (prev_stall) begin
                chk("rand_stall_mvalid", 32'(b_m_valid), 32'h1);
                chk("rand_stall_mdata", 32'(b_m_data), 32'(prev_data));
            end
        end
        b_s_valid = 0; b_flush = 0; b_m_ready = 0;
        chk("rand_beats_done", 32'(b_popped >= 2000), 32'h1);

        // Asynchronous reset mid-operation
        a_m_ready = 0; a_s_valid = 1; a_s_data = 8'h77;
        cycle();
        a_s_valid = 0;
        #2;
        rstn = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        chk("async_rst_mvalid", 32'(a_m_valid), 32'h0);
        chk("async_rst_count", 32'(a_count), 32'h0);
        chk("async_rst_sready", 32'(a_s_ready), 32'h1);
        chk("async_rst_b_count", 32'(b_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_fifo_buffer.md
Name: elastic_fifo_buffer

Overview:
Parametrised successor to the single-entry skid stage. It is a DEPTH-entry elastic buffer with a valid/ready handshake on both sides, a registered output stage and a registered s_ready, so there is no combinational path from m_ready to s_ready. It adds occupancy reporting, a programmable almost-full flag and a synchronous flush. It sits between producer and consumer pipeline stages where more than one beat of slack is needed, for example across long-latency backpressure.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 4, total capacity in beats, including the output register (>=2; non-power-of-2 allowed)
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH)
CNT_W, $clog2(DEPTH+1), width of count (derived localparam, not overridable)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
flush  input  1  synchronous discard of all stored beats
s_valid  input  1  upstream beat valid
s_ready  output  1  buffer can accept; driven only from registers
s_data  input  DATA_WIDTH  upstream payload
m_valid  output  1  output register holds a valid beat
m_ready  input  1  downstream accepts
m_data  output  DATA_WIDTH  payload, driven directly from a register
count  output  CNT_W  beats held (0..DEPTH)
almost_full  output  1  count >= AF_THRESH

Behaviour:
- Reset (rstn=0, asynchronous) values:
  - count=0, m_valid=0, m_data=0, almost_full=0 (AF_THRESH>=1), s_ready=1.
  - Ring pointers=0. Storage contents don't-care.
- Handshakes:
  - accept = s_valid & s_ready; pop = m_valid & m_ready.
  - m_valid/m_data stay stable while m_valid & !m_ready.
  - s_data is ignored when !s_ready.
- Structure:
  - Output register (1 entry) plus a ring store of DEPTH-1 entries.
  - Read and write pointers wrap from DEPTH-2 to 0 by compare, not by power-of-2 masking.
- Derived signals:
  - count_next = count + accept - pop (never over- or underflows).
  - m_valid == (count != 0) at all times.
  - s_ready = (count != DEPTH), computed from the registered count. When full, a same-cycle pop does not open s_ready until the next cycle (one bubble at full; accepted trade-off for timing isolation).
  - almost_full = (count >= AF_THRESH), registered-derived.
- Output register update, per cycle:
  - pop and ring non-empty: load ring head, advance read pointer.
  - pop and ring empty and accept: load s_data directly (bypass).
  - pop and ring empty and no accept: m_valid goes to 0.
  - no pop and !m_valid and accept: load s_data (bypass).
  - otherwise: hold.
- Ring write: an accept not consumed by the bypass writes s_data at the write pointer, then advances it.
- Ordering is strict FIFO. The bypass path may only be used when the ring is empty.
- Latency: 1 cycle from accept to m_valid when empty. Throughput 1 beat/cycle whenever count < DEPTH.
- flush=1:
  - Next cycle: count=0, m_valid=0, pointers=0, s_ready=1.
  - Any beat accepted or popped in the flush cycle is discarded/ignored; no beat is output after flush.
  - m_data need not be cleared.
- rstn asserted mid-operation: all beats are lost immediately and outputs return to reset values asynchronously.
- Simultaneous accept and pop at count=k (0<k<DEPTH): count stays k and order is preserved.

Decomposition:
- Shared common package: none required. CNT_W is a local derived parameter.
- One natural sub-module, elastic_ring_store: DEPTH-1 entry register array with wrapping write/read pointers and push/pop/clear inputs. It exposes head data and empty.
- Top-level logic holds count, output register, bypass mux and flags.

Test Plan:
1. Reset release -> m_valid=0, s_ready=1, count=0, almost_full=0.
2. Single beat 0xA5 at cycle 0 with m_ready=1 -> m_valid=1, m_data=0xA5 at cycle 1 with count=1; count=0, m_valid=0 at cycle 2.
3. Streaming: DEPTH=4, 16 back-to-back beats 0..15, m_ready=1 -> outputs 0..15 on consecutive cycles, s_ready never drops.
4. Backpressure: DEPTH=4, AF_THRESH=3, m_ready=0, push 1..5 -> accepts 1..4 with almost_full at count=3 and s_ready=0 at count=4. Then m_ready=1 -> outputs 1,2,3,4,5 in order with exactly one s_ready bubble.
5. Flush at count=3 with s_valid=1 in the same cycle -> next cycle count=0, m_valid=0; that beat and the 3 stored beats never appear.
6. DEPTH=5 (non-power-of-2), random s_valid/m_ready, 2000 beats -> scoreboard exact order match, count always equals scoreboard occupancy, m_data stable under stall.
